// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-stage definitions: byte constants, marker codes and the
// stuffer state type used by the luma/chroma stuffers and the header writer.
package jpeg_pkg;

    localparam logic [7:0]  BYTE_FF    = 8'hFF;
    localparam logic [7:0]  BYTE_STUFF = 8'h00;
    localparam logic [15:0] MARKER_EOI = 16'hFFD9;

    typedef enum logic {RUN, FLUSH} stuff_state_t;

endpackage

// File: rtl/ff_word_expand.sv
// Combinational 0xFF escape of one input word into up to 10 bytes (first byte at index 0).
// With FF_STUFF_EOI_EN defined, add_eoi appends the unstuffed EOI marker.
module ff_word_expand
    import jpeg_pkg::*;
(
    input  logic [31:0]     in_data,
    input  logic [2:0]      in_bytes,
`ifdef FF_STUFF_EOI_EN
    input  logic            add_eoi,
`endif
    output logic [9:0][7:0] exp_bytes,
    output logic [3:0]      exp_count
);

    logic [3:0] pos;
    logic [7:0] byte_v;

    always_comb begin
        exp_bytes = '0;
        pos       = 4'd0;
        byte_v    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) < in_bytes) begin
                byte_v         = in_data[31-8*i -: 8];
                exp_bytes[pos] = byte_v;
                pos            = pos + 4'd1;
                if (byte_v == BYTE_FF) begin
                    exp_bytes[pos] = BYTE_STUFF;
                    pos            = pos + 4'd1;
                end
            end
        end
`ifdef FF_STUFF_EOI_EN
        if (add_eoi) begin
            exp_bytes[pos]        = MARKER_EOI[15:8];
            exp_bytes[pos + 4'd1] = MARKER_EOI[7:0];
            pos                   = pos + 4'd2;
        end
`endif
        exp_count = pos;
    end

endmodule

// File: rtl/jpeg_ff_stuffer.sv
// JPEG 0xFF byte stuffer: expands input words into a circular byte buffer and repacks 32-bit words.
// Optional macro FF_STUFF_EOI_EN appends the EOI marker after the last word of a scan.
module jpeg_ff_stuffer
    import jpeg_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [2:0]  out_bytes
);

    localparam int unsigned PW = $clog2(BUF_BYTES);
    localparam int unsigned CW = $clog2(BUF_BYTES + 1);
    localparam logic [PW:0] BUF_W = BUF_BYTES[PW:0];

    logic [7:0]      buf_q [BUF_BYTES];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, push_n;
    stuff_state_t    state_q, state_d;

    logic [9:0][7:0] exp_bytes;
    logic [3:0]      exp_count;
    logic [2:0]      word_bytes;
    logic            accept;
    logic [2:0]      pop_n;
    logic            pop_last;
    logic [31:0]     pop_word;

    // Pointer advance modulo BUF_BYTES; offsets never exceed one lap, so one subtract suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [3:0] off);
        logic [PW:0] sum;
        sum = {1'b0, base} + {{(PW-3){1'b0}}, off};
        if (sum >= BUF_W)
            sum = sum - BUF_W;
        return sum[PW-1:0];
    endfunction

    assign in_ready   = (state_q == RUN) && (count_q <= CW'(BUF_BYTES - 10));
    assign accept     = in_valid && in_ready;
    assign word_bytes = in_last ? in_bytes : 3'd4;
    assign push_n     = accept ? CW'(exp_count) : '0;

    ff_word_expand u_expand (
        .in_data   (in_data),
        .in_bytes  (word_bytes),
`ifdef FF_STUFF_EOI_EN
        .add_eoi   (in_last),
`endif
        .exp_bytes (exp_bytes),
        .exp_count (exp_count)
    );

    always_comb begin
        state_d  = state_q;
        pop_n    = '0;
        pop_last = 1'b0;
        case (state_q)
            RUN: begin
                if (count_q >= CW'(4))
                    pop_n = 3'd4;
                if (accept && in_last)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (count_q != '0) begin
                    if (count_q <= CW'(4)) begin
                        pop_n    = count_q[2:0];
                        pop_last = 1'b1;
                        state_d  = RUN;
                    end else begin
                        pop_n = 3'd4;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pop_word = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (3'(k) < pop_n)
                pop_word[31-8*k -: 8] = buf_q[wrap_add(head_q, 4'(k))];
        end
    end

    // Push only writes free slots, so it never collides with the bytes being popped.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int unsigned k = 0; k < 10; k++) begin
                if (4'(k) < exp_count)
                    buf_q[wrap_add(tail_q, 4'(k))] <= exp_bytes[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_bytes <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_q + push_n - CW'(pop_n);
            if (accept)
                tail_q <= wrap_add(tail_q, exp_count);
            if (pop_n != '0)
                head_q <= wrap_add(head_q, {1'b0, pop_n});
            out_valid <= (pop_n != '0);
            out_data  <= pop_word;
            out_last  <= pop_last;
            out_bytes <= pop_n;
        end
    end

endmodule
